// File: rtl/dpram_port_master.sv
// dpram_port_master: clocked valid/ready initiator for one port of the
// asynchronous dual-port RAM. Sequences setup, ce strobe and recovery
// phases, owns the data-bus direction and returns read data on a
// one-cycle response pulse.
module dpram_port_master #(
  parameter int unsigned A_WIDTH    = 8,
  parameter int unsigned D_WIDTH    = 8,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned RECOV_CYC  = 1
) (
  input  logic               clk,
  input  logic               rst,
  // request side
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_wr,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [D_WIDTH-1:0] req_wdata,
  // response side
  output logic               rsp_valid,
  output logic               rsp_wr,
  output logic [D_WIDTH-1:0] rsp_rdata,
  // RAM port
  output logic               ram_rst_n,
  output logic               ram_ce,
  output logic               ram_oe,
  output logic               ram_we,
  output logic [A_WIDTH-1:0] ram_addr,
  output logic [D_WIDTH-1:0] ram_dout,
  output logic               ram_dout_en,
  input  logic [D_WIDTH-1:0] ram_din
);

  localparam int unsigned CNT_W = 8;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_LD  = CNT_W'(RECOV_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lat_wr_q, lat_wr_d;

  logic               req_ready_d;
  logic               rsp_valid_d;
  logic               rsp_wr_d;
  logic [D_WIDTH-1:0] rsp_rdata_d;
  logic               ram_ce_d;
  logic               ram_oe_d;
  logic               ram_we_d;
  logic [A_WIDTH-1:0] ram_addr_d;
  logic [D_WIDTH-1:0] ram_dout_d;
  logic               ram_dout_en_d;

  // State, phase counter and every output are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_wr_q    <= 1'b0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_wr      <= 1'b0;
      rsp_rdata   <= '0;
      ram_rst_n   <= 1'b0;
      ram_ce      <= 1'b1;
      ram_oe      <= 1'b1;
      ram_we      <= 1'b1;
      ram_addr    <= '0;
      ram_dout    <= '0;
      ram_dout_en <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_wr_q    <= lat_wr_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_wr      <= rsp_wr_d;
      rsp_rdata   <= rsp_rdata_d;
      ram_rst_n   <= 1'b1;
      ram_ce      <= ram_ce_d;
      ram_oe      <= ram_oe_d;
      ram_we      <= ram_we_d;
      ram_addr    <= ram_addr_d;
      ram_dout    <= ram_dout_d;
      ram_dout_en <= ram_dout_en_d;
    end
  end

  // Next-state and next-output logic; outputs describe the state being entered
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lat_wr_d      = lat_wr_q;
    req_ready_d   = req_ready;
    rsp_valid_d   = 1'b0;
    rsp_wr_d      = rsp_wr;
    rsp_rdata_d   = rsp_rdata;
    ram_ce_d      = ram_ce;
    ram_oe_d      = ram_oe;
    ram_we_d      = ram_we;
    ram_addr_d    = ram_addr;
    ram_dout_d    = ram_dout;
    ram_dout_en_d = ram_dout_en;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          state_d     = SETUP;
          cnt_d       = SETUP_LD;
          lat_wr_d    = req_wr;
          req_ready_d = 1'b0;
          ram_addr_d  = req_addr;
          ram_ce_d    = 1'b1;
          if (req_wr) begin
            // Write: master owns the bus, RAM output stays disabled
            ram_oe_d      = 1'b1;
            ram_we_d      = 1'b0;
            ram_dout_d    = req_wdata;
            ram_dout_en_d = 1'b1;
          end else begin
            // Read: RAM owns the bus, master releases it
            ram_oe_d      = 1'b0;
            ram_we_d      = 1'b1;
            ram_dout_en_d = 1'b0;
          end
        end
      end

      SETUP: begin
        if (cnt_q == '0) begin
          state_d  = STROBE;
          cnt_d    = STROBE_LD;
          ram_ce_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      STROBE: begin
        if (cnt_q == '0) begin
          if (!lat_wr_q) begin
            rsp_rdata_d = ram_din;
          end
          state_d       = RECOVER;
          cnt_d         = RECOV_LD;
          rsp_valid_d   = 1'b1;
          rsp_wr_d      = lat_wr_q;
          ram_ce_d      = 1'b1;
          ram_oe_d      = 1'b1;
          ram_we_d      = 1'b1;
          ram_dout_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RECOVER: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dpram_port_master.sv
// Directed bench for dpram_port_master: a default-timing instance and a
// stretched-timing instance, each attached to a simple behavioural RAM.
module tb_dpram_port_master;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       hold;
  } vec_t;

  typedef struct {
    logic       req_ready;
    logic       rsp_valid;
    logic       rsp_wr;
    logic [7:0] rsp_rdata;
    logic       rst_n;
    logic       ce;
    logic       oe;
    logic       we;
    logic [7:0] addr;
    logic [7:0] dout;
    logic       dout_en;
  } obs_t;

  logic clk;
  logic rst;
  logic req_valid0, req_valid1;
  logic req_wr;
  logic [7:0] req_addr, req_wdata;

  logic       req_ready0, rsp_valid0, rsp_wr0, ram_rst_n0, ram_ce0, ram_oe0, ram_we0, ram_dout_en0;
  logic [7:0] rsp_rdata0, ram_addr0, ram_dout0, ram_din0;
  logic       req_ready1, rsp_valid1, rsp_wr1, ram_rst_n1, ram_ce1, ram_oe1, ram_we1, ram_dout_en1;
  logic [7:0] rsp_rdata1, ram_addr1, ram_dout1, ram_din1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit bus_bad_any = 0;

  vec_t vecs0 [8];
  vec_t vecs1 [2];

  dpram_port_master dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_wr(rsp_wr0), .rsp_rdata(rsp_rdata0),
    .ram_rst_n(ram_rst_n0), .ram_ce(ram_ce0), .ram_oe(ram_oe0), .ram_we(ram_we0),
    .ram_addr(ram_addr0), .ram_dout(ram_dout0), .ram_dout_en(ram_dout_en0),
    .ram_din(ram_din0)
  );

  dpram_port_master #(.SETUP_CYC(2), .STROBE_CYC(4), .RECOV_CYC(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_wr(rsp_wr1), .rsp_rdata(rsp_rdata1),
    .ram_rst_n(ram_rst_n1), .ram_ce(ram_ce1), .ram_oe(ram_oe1), .ram_we(ram_we1),
    .ram_addr(ram_addr1), .ram_dout(ram_dout1), .ram_dout_en(ram_dout_en1),
    .ram_din(ram_din1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural asynchronous RAMs: write on ce fall, read while ce and oe low
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
  end
  always @(negedge ram_ce0) if (!ram_we0 && ram_dout_en0) mem0[ram_addr0] = ram_dout0;
  always @(negedge ram_ce1) if (!ram_we1 && ram_dout_en1) mem1[ram_addr1] = ram_dout1;
  assign ram_din0 = (!ram_ce0 && !ram_oe0) ? mem0[ram_addr0] : 8'h00;
  assign ram_din1 = (!ram_ce1 && !ram_oe1) ? mem1[ram_addr1] : 8'h00;

  // Continuous bus-contention watch on both instances
  always @(negedge clk) begin
    if (ram_dout_en0 === 1'b1 && ram_oe0 === 1'b0) bus_bad_any = 1'b1;
    if (ram_dout_en1 === 1'b1 && ram_oe1 === 1'b0) bus_bad_any = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic snap(input bit s, output obs_t o);
    if (!s) begin
      o.req_ready = req_ready0; o.rsp_valid = rsp_valid0; o.rsp_wr = rsp_wr0;
      o.rsp_rdata = rsp_rdata0; o.rst_n = ram_rst_n0; o.ce = ram_ce0; o.oe = ram_oe0;
      o.we = ram_we0; o.addr = ram_addr0; o.dout = ram_dout0; o.dout_en = ram_dout_en0;
    end else begin
      o.req_ready = req_ready1; o.rsp_valid = rsp_valid1; o.rsp_wr = rsp_wr1;
      o.rsp_rdata = rsp_rdata1; o.rst_n = ram_rst_n1; o.ce = ram_ce1; o.oe = ram_oe1;
      o.we = ram_we1; o.addr = ram_addr1; o.dout = ram_dout1; o.dout_en = ram_dout_en1;
    end
  endtask

  task automatic chk_reset_vals(input bit s, input logic exp_rst_n);
    obs_t o;
    snap(s, o);
    chk($sformatf("rst%0d_req_ready", s), 32'(o.req_ready), 32'd1);
    chk($sformatf("rst%0d_rsp_valid", s), 32'(o.rsp_valid), 32'd0);
    chk($sformatf("rst%0d_rsp_wr", s),    32'(o.rsp_wr),    32'd0);
    chk($sformatf("rst%0d_rsp_rdata", s), 32'(o.rsp_rdata), 32'd0);
    chk($sformatf("rst%0d_ce", s),        32'(o.ce),        32'd1);
    chk($sformatf("rst%0d_oe", s),        32'(o.oe),        32'd1);
    chk($sformatf("rst%0d_we", s),        32'(o.we),        32'd1);
    chk($sformatf("rst%0d_addr", s),      32'(o.addr),      32'd0);
    chk($sformatf("rst%0d_dout", s),      32'(o.dout),      32'd0);
    chk($sformatf("rst%0d_dout_en", s),   32'(o.dout_en),   32'd0);
    chk($sformatf("rst%0d_ram_rst_n", s), 32'(o.rst_n),     32'(exp_rst_n));
  endtask

  // One access: drive request, follow it to req_ready, check the phase timing
  task automatic run_access(input bit s, input vec_t v, input string tag,
                            input int e_ce1, input int e_ce_n, input int e_rsp,
                            input int e_rdy, output int acc_cyc);
    obs_t o, su;
    bit rb, acc, prev_ce, bad, rw;
    int rel, ce_low, falls, ce_first, rsp_rel, nrsp, rdy_rel;
    logic [7:0] rd, mv;
    acc = 0; prev_ce = 1; bad = 0; rw = 0; rel = 0; ce_low = 0; falls = 0;
    ce_first = -1; rsp_rel = -1; nrsp = 0; rdy_rel = -1; rd = 8'h00; acc_cyc = -1;
    snap(s, su);
    req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    if (s) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    for (int n = 0; n < 64; n++) begin
      if (rdy_rel >= 0) break;
      snap(s, o);
      rb = o.req_ready;
      @(posedge clk); #1;
      snap(s, o);
      if (acc) rel++;
      else if (rb) begin
        acc = 1; rel = 1; acc_cyc = cyc;
        if (!v.hold) begin req_valid0 = 1'b0; req_valid1 = 1'b0; end
      end
      if (acc) begin
        if (rel == 1) su = o;
        if (!o.ce) begin ce_low++; if (ce_first < 0) ce_first = rel; end
        if (prev_ce && !o.ce) falls++;
        prev_ce = o.ce;
        if (o.dout_en && !o.oe) bad = 1;
        if (o.rsp_valid) begin nrsp++; rsp_rel = rel; rw = o.rsp_wr; rd = o.rsp_rdata; end
        if (o.req_ready) rdy_rel = rel;
      end
    end
    chk({tag, "_accepted"},   32'(acc),        32'd1);
    chk({tag, "_setup_ce"},   32'(su.ce),      32'd1);
    chk({tag, "_setup_addr"}, 32'(su.addr),    32'(v.addr));
    chk({tag, "_setup_oe"},   32'(su.oe),      32'(v.wr));
    chk({tag, "_setup_we"},   32'(su.we),      32'(!v.wr));
    chk({tag, "_setup_den"},  32'(su.dout_en), 32'(v.wr));
    if (v.wr) chk({tag, "_setup_dout"}, 32'(su.dout), 32'(v.wdata));
    chk({tag, "_ce_first"},   32'(ce_first),   32'(e_ce1));
    chk({tag, "_ce_low"},     32'(ce_low),     32'(e_ce_n));
    chk({tag, "_ce_falls"},   32'(falls),      32'd1);
    chk({tag, "_rsp_cycle"},  32'(rsp_rel),    32'(e_rsp));
    chk({tag, "_rsp_count"},  32'(nrsp),       32'd1);
    chk({tag, "_rsp_wr"},     32'(rw),         32'(v.wr));
    chk({tag, "_rsp_rdata"},  32'(rd),         32'(v.exp_rdata));
    chk({tag, "_ready_cyc"},  32'(rdy_rel),    32'(e_rdy));
    chk({tag, "_bus_rule"},   32'(bad),        32'd0);
    if (v.wr) begin
      mv = s ? mem1[v.addr] : mem0[v.addr];
      chk({tag, "_ram_mem"}, 32'(mv), 32'(v.wdata));
    end
  endtask

  initial begin
    int a_prev, a_cur, ce_lows, rsps;
    obs_t o;

    vecs0[0] = '{1'b1, 8'h12, 8'hA5, 8'h00, 1'b0};
    vecs0[1] = '{1'b0, 8'h12, 8'h00, 8'hA5, 1'b0};
    vecs0[2] = '{1'b1, 8'h01, 8'h11, 8'hA5, 1'b1};
    vecs0[3] = '{1'b1, 8'h02, 8'h22, 8'hA5, 1'b0};
    vecs0[4] = '{1'b0, 8'h01, 8'h00, 8'h11, 1'b0};
    vecs0[5] = '{1'b0, 8'h02, 8'h00, 8'h22, 1'b0};
    vecs0[6] = '{1'b1, 8'hFF, 8'h5A, 8'h22, 1'b0};
    vecs0[7] = '{1'b0, 8'hFF, 8'h00, 8'h5A, 1'b0};
    vecs1[0] = '{1'b1, 8'h34, 8'hC3, 8'h00, 1'b0};
    vecs1[1] = '{1'b0, 8'h34, 8'h00, 8'hC3, 1'b0};

    rst = 1'b1; req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_wr = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;

    // Reset held three cycles, then release
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals(0, 1'b0);
    chk_reset_vals(1, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_ram_rst_n0", 32'(ram_rst_n0), 32'd1);
    chk("rel_ram_rst_n1", 32'(ram_rst_n1), 32'd1);
    chk("rel_req_ready0", 32'(req_ready0), 32'd1);

    // Default-timing table: accept k, ce low k+2..k+3, rsp k+4, ready k+5
    a_prev = 0;
    for (int i = 0; i < 8; i++) begin
      run_access(0, vecs0[i], $sformatf("v0_%0d", i), 2, 2, 4, 5, a_cur);
      if (i == 3) chk("b2b_accept_gap", 32'(a_cur - a_prev), 32'd5);
      a_prev = a_cur;
    end

    // Stretched timing: setup 2, strobe 4 -> rsp k+7, occupancy 8
    for (int i = 0; i < 2; i++) begin
      run_access(1, vecs1[i], $sformatf("v1_%0d", i), 3, 4, 7, 8, a_cur);
    end

    // Reset during the strobe of a read
    req_wr = 1'b0; req_addr = 8'h01; req_valid0 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("mid_setup_oe", 32'(ram_oe0), 32'd0);
    @(posedge clk); #1;
    chk("mid_strobe_ce", 32'(ram_ce0), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals(0, 1'b0);
    ce_lows = 0; rsps = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      snap(0, o);
      if (!o.ce) ce_lows++;
      if (o.rsp_valid) rsps++;
    end
    chk("mid_no_rsp", 32'(rsps), 32'd0);
    chk("mid_no_ce", 32'(ce_lows), 32'd0);
    run_access(0, '{1'b0, 8'h02, 8'h00, 8'h22, 1'b0}, "post_rst_rd", 2, 2, 4, 5, a_cur);

    chk("bus_rule_global", 32'(bus_bad_any), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram_port_master.md
Name: dpram_port_master

Overview:
- Synchronous initiator that drives one port (left or right) of the asynchronous dual-port RAM.
- Converts a clocked valid/ready request interface into the RAM's active-low, strobe-edge port protocol:
  - ce falling edge triggers the access.
  - oe=1, we=0 selects write; oe=0, we=1 selects read.
- Controls the data bus direction so master and RAM never drive together.
- Returns read data on a one-cycle response pulse.
- One instance per RAM port.

Parameters:
- A_WIDTH, 8, address width (must match the RAM).
- D_WIDTH, 8, data width (must match the RAM).
- SETUP_CYC, 1, cycles that addr/oe/we/data are stable before ce falls; range 1..255.
- STROBE_CYC, 2, cycles ce is held low; range 1..255.
- RECOV_CYC, 1, cycles with ce/oe/we high before the next access; range 1..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  A_WIDTH  access address.
- req_wdata  in  D_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_wr  out  1  type of the completed access.
- rsp_rdata  out  D_WIDTH  read data; valid when rsp_valid && !rsp_wr.
- ram_rst_n  out  1  RAM memory-clear control, active-low.
- ram_ce  out  1  RAM chip enable, active-low strobe.
- ram_oe  out  1  RAM output enable, active-low.
- ram_we  out  1  RAM write enable, active-low.
- ram_addr  out  A_WIDTH  RAM address.
- ram_dout  out  D_WIDTH  data driven toward the RAM bus.
- ram_dout_en  out  1  tristate enable for ram_dout; the top level builds the inout.
- ram_din  in  D_WIDTH  RAM bus value as seen by the master.

Behaviour:
- All outputs are registered.
- Reset values (while rst=1 and on the first cycle after):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_wr=0, rsp_rdata=0.
  - ram_ce=1, ram_oe=1, ram_we=1, ram_addr=0, ram_dout=0, ram_dout_en=0.
  - ram_rst_n=0 while rst=1; goes to 1 one cycle after rst deasserts.
- States: IDLE, SETUP, STROBE, RECOVER. An 8-bit down-counter times each non-IDLE state.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready: latch req_wr/addr/wdata, go to SETUP, load counter SETUP_CYC-1, drop req_ready.
- SETUP:
  - ram_addr=latched addr; ram_ce=1.
  - Write: ram_oe=1, ram_we=0, ram_dout=wdata, ram_dout_en=1.
  - Read: ram_oe=0, ram_we=1, ram_dout_en=0.
  - When counter==0: go to STROBE, load STROBE_CYC-1.
- STROBE:
  - ram_ce=0; addr/oe/we/dout/dout_en unchanged.
  - When counter==0: for reads, capture ram_din into rsp_rdata. Then go to RECOVER, load RECOV_CYC-1, and pulse rsp_valid=1 with rsp_wr=latched wr for one cycle.
- RECOVER:
  - ram_ce=1, ram_oe=1, ram_we=1, ram_dout_en=0; ram_addr holds.
  - When counter==0: go to IDLE, req_ready=1.
- Timing with defaults:
  - Accept on edge k.
  - SETUP in cycle k+1; ce low in k+2..k+3; rsp_valid in k+4; req_ready high in k+5.
  - General occupancy: SETUP_CYC+STROBE_CYC+RECOV_CYC+1 cycles per access.
- Bus rule:
  - ram_dout_en=1 only in SETUP/STROBE of a write.
  - ram_dout_en and !ram_oe are never both 1 in any cycle.
- ram_ce falls only on the SETUP→STROBE transition; exactly one falling edge per accepted request.
- Request inputs are ignored when req_ready=0. A held req_valid is accepted on the first IDLE cycle.
- rsp_rdata holds its last read value until the next read completes; writes do not alter it.
- Reset mid-operation:
  - Next edge forces the reset values; ram_ce returns to 1; no rsp_valid is generated.
  - A write whose ce fall has already occurred is committed in the RAM. The master makes no further guarantee.
- The master does not arbitrate between ports; same-address collisions are resolved by the RAM.

Test Plan:
- Reset: hold rst 3 cycles → all outputs at reset values, ram_rst_n=0. Release → ram_rst_n=1 the next cycle, req_ready=1.
- Write addr 0x12 data 0xA5, defaults → SETUP cycle with ram_we=0, ram_oe=1, ram_dout_en=1, ram_dout=0xA5; ram_ce low exactly 2 cycles; rsp_valid=1, rsp_wr=1 at k+4; RAM model holds 0xA5 at 0x12.
- Read back 0x12 → ram_oe=0, ram_we=1, ram_dout_en=0 throughout; rsp_valid with rsp_wr=0 and rsp_rdata=0xA5 at k+4; ram_dout_en && !ram_oe never both 1.
- Back-to-back: req_valid held high for writes 0x01→0x11 and 0x02→0x22 → second accept exactly 5 cycles after the first; one ce fall per access; reads return 0x11 and 0x22.
- STROBE_CYC=4, SETUP_CYC=2 → ce low 4 cycles; rsp_valid at k+7; occupancy 8 cycles.
- Assert rst during STROBE of a read → ram_ce=1 next cycle, no rsp_valid, rsp_rdata=0; a subsequent read completes normally.
